ctrl_pipe_md: RTL and testbench

Parametrised pipeline-control backend for the five-stage MIPS core. Takes the decoded control word and valid bit from Decode and carries them through the Execute, Memory and Writeback pipeline registers, with configurable field widths per stage. Adds a multi-cycle multiply/divide sequencer with HI/LO interlock, so `muldiv`, `mflo` and `mfhi` no longer have to complete in one cycle. Sits between the main/ALU decoders and the datapath; its stall request feeds the hazard unit.

---
 rtl/ctrl_pipe_md.sv | 140 ++++++++++++++
 tb/tb_ctrl_pipe_md.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_md.sv
// Control-word pipeline (D->E->M->W) with a multi-cycle mul/div sequencer and HI/LO interlock.
// Optional performance counters are built when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe_md #(
  parameter int unsigned CWE    = 8,
  parameter int unsigned CWM    = 4,
  parameter int unsigned CWW    = 3,
  parameter int unsigned MD_LAT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     validD,
  input  logic [CWW+CWM+CWE-1:0]   ctrlD,
  input  logic                     muldivD,
  input  logic                     mfD,
  input  logic                     flushE,
  input  logic                     stallD,
  output logic [CWW+CWM+CWE-1:0]   ctrlE,
  output logic [CWW+CWM-1:0]       ctrlM,
  output logic [CWW-1:0]           ctrlW,
  output logic                     validE,
  output logic                     validM,
  output logic                     validW,
  output logic                     muldivE,
  output logic                     md_busy,
  output logic                     md_done,
  output logic                     md_stallD,
  output logic [31:0]              perf_stall,
  output logic [31:0]              perf_retire
);

  localparam int unsigned CW   = CWW + CWM + CWE;
  localparam int unsigned CWMW = CWW + CWM;
  localparam logic [3:0]  MD_LAT_C = 4'(MD_LAT);

  logic [CW-1:0]   ctrl_e_q,   ctrl_e_d;
  logic            valid_e_q,  valid_e_d;
  logic            muldiv_e_q, muldiv_e_d;
  logic [CWMW-1:0] ctrl_m_q,   ctrl_m_d;
  logic            valid_m_q,  valid_m_d;
  logic [CWW-1:0]  ctrl_w_q,   ctrl_w_d;
  logic            valid_w_q,  valid_w_d;
  logic [3:0]      cnt_q,      cnt_d;
  logic            md_start;
  logic            busy;
  logic            stall_md;
  logic            accept;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    md_start   = valid_e_q & muldiv_e_q;
    busy       = (cnt_q != 4'd0) | md_start;
    // Only registered state and D inputs feed the stall, never flushE/stallD.
    stall_md   = validD & (muldivD | mfD) & busy;
    accept     = ~(flushE | stallD | stall_md);

    ctrl_e_d   = '0;
    valid_e_d  = 1'b0;
    muldiv_e_d = 1'b0;
    if (accept) begin
      ctrl_e_d   = ctrlD;
      valid_e_d  = validD;
      muldiv_e_d = muldivD;
    end

    ctrl_m_d  = ctrl_e_q[CW-1 -: CWMW];
    valid_m_d = valid_e_q;
    ctrl_w_d  = ctrl_m_q[CWMW-1 -: CWW];
    valid_w_d = valid_m_q;

    cnt_d = cnt_q;
    if (md_start) begin
      cnt_d = MD_LAT_C;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_e_q   <= '0;
      valid_e_q  <= 1'b0;
      muldiv_e_q <= 1'b0;
      ctrl_m_q   <= '0;
      valid_m_q  <= 1'b0;
      ctrl_w_q   <= '0;
      valid_w_q  <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      ctrl_e_q   <= ctrl_e_d;
      valid_e_q  <= valid_e_d;
      muldiv_e_q <= muldiv_e_d;
      ctrl_m_q   <= ctrl_m_d;
      valid_m_q  <= valid_m_d;
      ctrl_w_q   <= ctrl_w_d;
      valid_w_q  <= valid_w_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] perf_stall_q,  perf_stall_d;
  logic [31:0] perf_retire_q, perf_retire_d;

  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_retire_d = perf_retire_q;
    if (stall_md | stallD) perf_stall_d = perf_stall_q + 32'd1;
    if (valid_w_q)         perf_retire_d = perf_retire_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q  <= 32'd0;
      perf_retire_q <= 32'd0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_retire_q <= perf_retire_d;
    end
  end

  assign perf_stall  = perf_stall_q;
  assign perf_retire = perf_retire_q;
`else
  assign perf_stall  = 32'd0;
  assign perf_retire = 32'd0;
`endif

  assign ctrlE     = ctrl_e_q;
  assign validE    = valid_e_q;
  assign muldivE   = muldiv_e_q;
  assign ctrlM     = ctrl_m_q;
  assign validM    = valid_m_q;
  assign ctrlW     = ctrl_w_q;
  assign validW    = valid_w_q;
  assign md_busy   = busy;
  assign md_done   = (cnt_q == 4'd1);
  assign md_stallD = stall_md;

endmodule

// File: tb/tb_ctrl_pipe_md.sv
// Directed bench for ctrl_pipe_md: a scoreboard tracks accepted control words to Writeback,
// directed checks cover reset, flush, mul/div interlock, abandoned mul/div and perf counters.
module tb_ctrl_pipe_md;

  localparam int unsigned CWE = 8, CWM = 4, CWW = 3, MD_LAT = 4;
  localparam int unsigned CW  = CWW + CWM + CWE;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 validD, muldivD, mfD, flushE, stallD;
  logic [CW-1:0]        ctrlD;
  logic [CW-1:0]        ctrlE;
  logic [CWW+CWM-1:0]   ctrlM;
  logic [CWW-1:0]       ctrlW;
  logic                 validE, validM, validW, muldivE;
  logic                 md_busy, md_done, md_stallD;
  logic [31:0]          perf_stall, perf_retire;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CWW-1:0] sb_q[$];

  localparam logic [CW-1:0] C_MULT = 15'h5155;
  localparam logic [CW-1:0] C_MFLO = 15'h3A6C;
  logic [CW-1:0] c_add [6];

  always #5 clk = ~clk;

  ctrl_pipe_md #(.CWE(CWE), .CWM(CWM), .CWW(CWW), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .reset(reset), .validD(validD), .ctrlD(ctrlD), .muldivD(muldivD),
    .mfD(mfD), .flushE(flushE), .stallD(stallD), .ctrlE(ctrlE), .ctrlM(ctrlM),
    .ctrlW(ctrlW), .validE(validE), .validM(validM), .validW(validW),
    .muldivE(muldivE), .md_busy(md_busy), .md_done(md_done), .md_stallD(md_stallD),
    .perf_stall(perf_stall), .perf_retire(perf_retire)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive D-stage inputs; acc marks an instruction the bench knows will enter E.
  task automatic drv(input logic v, input logic [CW-1:0] c, input logic md, input logic mf,
                     input logic fl, input logic st, input bit acc);
    validD = v; ctrlD = c; muldivD = md; mfD = mf; flushE = fl; stallD = st;
    if (acc) sb_q.push_back(c[CW-1 -: CWW]);
  endtask

  task automatic idle();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Writeback monitor: every valid W slot must match the oldest accepted word.
  always @(negedge clk) begin
    if (reset && validW) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_bad++;
        $error("FAIL sb_underflow: observed validW=1 expected no instruction in W");
      end
      if (sb_q.size() != 0) check("sb_ctrlW", 32'(ctrlW), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 6; i++) c_add[i] = 15'((i + 1) * 4099 + 17);

    // Reset held low with an all-ones valid instruction in D.
    reset = 1'b0;
    drv(1'b1, '1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    mid();
    check("rst_ctrlE", 32'(ctrlE), 0);
    check("rst_ctrlM", 32'(ctrlM), 0);
    check("rst_ctrlW", 32'(ctrlW), 0);
    check("rst_validE", 32'(validE), 0);
    check("rst_validM", 32'(validM), 0);
    check("rst_validW", 32'(validW), 0);
    check("rst_muldivE", 32'(muldivE), 0);
    check("rst_md_busy", 32'(md_busy), 0);
    check("rst_md_done", 32'(md_done), 0);
    check("rst_md_stallD", 32'(md_stallD), 0);
    check("rst_perf_stall", perf_stall, 0);
    check("rst_perf_retire", perf_retire, 0);

    // Release: the all-ones word walks E, M, W with truncation.
    next();
    reset = 1'b1;
    drv(1'b1, '1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mid();
    check("rel_validE_c0", 32'(validE), 0);
    next(); idle(); mid();
    check("lat_ctrlE", 32'(ctrlE), 32'h7FFF);
    check("lat_validE", 32'(validE), 1);
    check("lat_ctrlM_early", 32'(ctrlM), 0);
    next(); idle(); mid();
    check("lat_ctrlM", 32'(ctrlM), 32'h7F);
    check("lat_validM", 32'(validM), 1);
    check("lat_validE_gone", 32'(validE), 0);
    next(); mid();
    check("lat_ctrlW", 32'(ctrlW), 32'h7);
    check("lat_validW", 32'(validW), 1);
    next();

    // Flush a valid add for one cycle.
    drv(1'b1, c_add[0], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mid(); next(); idle(); mid();
    check("flush_validE", 32'(validE), 0);
    check("flush_ctrlE", 32'(ctrlE), 0);
    next(); mid();
    check("flush_validM", 32'(validM), 0);
    next();

    // mult then a dependent mflo held in D by the interlock.
    drv(1'b1, C_MULT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    mid(); next();
    for (int k = 0; k < 5; k++) begin
      drv(1'b1, C_MFLO, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      mid();
      check($sformatf("ilk_stallD_t%0d", k), 32'(md_stallD), 1);
      check($sformatf("ilk_busy_t%0d", k), 32'(md_busy), 1);
      check($sformatf("ilk_done_t%0d", k), 32'(md_done), 32'(k == 4));
      if (k == 0) check("ilk_muldivE_t0", 32'(muldivE), 1);
      else        check($sformatf("ilk_bubble_t%0d", k), 32'(validE), 0);
      next();
    end
    drv(1'b1, C_MFLO, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    mid();
    check("ilk_release_stallD", 32'(md_stallD), 0);
    check("ilk_release_busy", 32'(md_busy), 0);
    next(); idle(); mid();
    check("mflo_validE_t6", 32'(validE), 1);
    check("mflo_ctrlE_t6", 32'(ctrlE), 32'(C_MFLO));
    check("mflo_muldivE_t6", 32'(muldivE), 0);
    next();

    // mult followed by independent adds: no stall, adds flow to W.
    drv(1'b1, C_MULT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    mid(); next();
    for (int k = 1; k <= 3; k++) begin
      drv(1'b1, c_add[k-1], 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      mid();
      check($sformatf("ind_stallD_c%0d", k), 32'(md_stallD), 0);
      check($sformatf("ind_busy_c%0d", k), 32'(md_busy), 1);
      next();
    end
    idle(); mid();
    check("ind_validW_c4", 32'(validW), 1);
    check("ind_busy_c4", 32'(md_busy), 1);
    next(); mid();
    check("ind_validW_c5", 32'(validW), 1);
    check("ind_done_c5", 32'(md_done), 1);
    next(); mid();
    check("ind_validW_c6", 32'(validW), 1);
    check("ind_busy_c6", 32'(md_busy), 0);
    next();
    for (int k = 3; k < 6; k++) begin
      drv(1'b1, c_add[k], 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      mid(); next();
    end
    idle();
    repeat (6) begin mid(); next(); end
    check("sb_drain", 32'(sb_q.size()), 0);
`ifdef CTRL_PIPE_PERF_EN
    check("perf_retire", perf_retire, 10);
    check("perf_stall", perf_stall, 5);
`else
    check("perf_retire_off", perf_retire, 0);
    check("perf_stall_off", perf_stall, 0);
`endif

    // stallD alone bubbles E and does not raise md_stallD.
    drv(1'b1, C_MFLO, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    mid();
    check("stallD_no_md_stall", 32'(md_stallD), 0);
    next(); idle(); mid();
    check("stallD_validE", 32'(validE), 0);
`ifdef CTRL_PIPE_PERF_EN
    check("perf_stall_stallD", perf_stall, 6);
`else
    check("perf_stall_stallD_off", perf_stall, 0);
`endif
    next();

    // Reset at t=2 of a mul/div abandons the result.
    drv(1'b1, C_MULT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    mid(); next(); idle();
    mid();
    check("abort_busy_t0", 32'(md_busy), 1);
    next(); mid(); next(); mid();
    check("abort_busy_t2", 32'(md_busy), 1);
    #2 reset = 1'b0;
    #1;
    check("abort_busy_now", 32'(md_busy), 0);
    check("abort_done_now", 32'(md_done), 0);
    check("abort_validW", 32'(validW), 0);
    check("abort_perf_retire", perf_retire, 0);
    next();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mid();
      check($sformatf("abort_no_done_%0d", k), 32'(md_done), 0);
      check($sformatf("abort_no_busy_%0d", k), 32'(md_busy), 0);
      next();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
